// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Multiply: acc is the running product, fed multiplier bits MSB first.
// Divide:   acc[2W-1:W] is the partial remainder, acc[W-1:0] collects quotient
//           bits; dividend bits are fed MSB first.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_bit,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_mul;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem;

  // Compute both candidate iterations and select by mode.
  always_comb begin
    w_mul   = {i_acc[2*WIDTH-2:0], 1'b0} +
              {{WIDTH{1'b0}}, (i_bit ? i_opnd : {WIDTH{1'b0}})};
    w_shift = {i_acc[2*WIDTH-1:WIDTH], i_bit};
    w_trial = w_shift - {1'b0, i_opnd};
    w_ge    = (w_shift >= {1'b0, i_opnd});
    // The restored remainder is always below the divisor, so it fits WIDTH bits.
    if (w_ge) begin
      w_rem = w_trial[WIDTH-1:0];
    end else begin
      w_rem = w_shift[WIDTH-1:0];
    end
    if (i_div) begin
      o_acc = {w_rem, i_acc[WIDTH-2:0], w_ge};
    end else begin
      o_acc = w_mul;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is fixed up in the FIX state.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod;
  logic [WIDTH-1:0]   r_opa, r_opb, r_hi, r_lo;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_hi_fix, w_lo_fix;
  logic               r_div, r_sgn, r_neg_a, r_neg_b, r_done;
  logic               w_idle, w_launch, w_mt;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_launch = start && w_idle && (op[2] == 1'b0);
  assign w_mt     = start && w_idle && ((op == OP_MTHI) || (op == OP_MTLO));

  assign busy = !w_idle;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_opnd (r_opb),
    .i_bit  (r_opa[WIDTH-1]),
    .o_acc  (w_acc_step)
  );

  // Operand magnitudes: signed ops (op[0]==0) take the absolute value.
  always_comb begin
    if ((op[0] == 1'b0) && a[WIDTH-1]) begin
      w_abs_a = -a;
    end else begin
      w_abs_a = a;
    end
    if ((op[0] == 1'b0) && b[WIDTH-1]) begin
      w_abs_b = -b;
    end else begin
      w_abs_b = b;
    end
  end

  // Sign correction and divide-by-zero handling for the final HI/LO values.
  always_comb begin
    if (r_sgn && (r_neg_a ^ r_neg_b)) begin
      w_prod = -r_acc;
    end else begin
      w_prod = r_acc;
    end
    // A zero divisor yields an all-ones quotient; the remainder already equals |a|.
    if (r_opb == {WIDTH{1'b0}}) begin
      w_quo = {WIDTH{1'b1}};
    end else if (r_sgn && (r_neg_a ^ r_neg_b)) begin
      w_quo = -r_acc[WIDTH-1:0];
    end else begin
      w_quo = r_acc[WIDTH-1:0];
    end
    if (r_sgn && r_neg_a) begin
      w_rem = -r_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_rem = r_acc[2*WIDTH-1:WIDTH];
    end
    if (r_div) begin
      w_hi_fix = w_rem;
      w_lo_fix = w_quo;
    end else begin
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_next = ST_FIX;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= {CW{1'b0}};
      r_acc   <= {(2*WIDTH){1'b0}};
      r_opa   <= {WIDTH{1'b0}};
      r_opb   <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
      r_div   <= 1'b0;
      r_sgn   <= 1'b0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_div   <= op[1];
        r_sgn   <= ~op[0];
        r_neg_a <= ~op[0] & a[WIDTH-1];
        r_neg_b <= ~op[0] & b[WIDTH-1];
        r_opa   <= w_abs_a;
        r_opb   <= w_abs_b;
        r_acc   <= {(2*WIDTH){1'b0}};
        r_cnt   <= {CW{1'b0}};
      end else if (w_mt) begin
        if (op == OP_MTHI) begin
          r_hi <= a;
        end else begin
          r_lo <= a;
        end
        r_done <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_acc_step;
        r_opa <= {r_opa[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == ST_FIX) begin
        r_hi   <= w_hi_fix;
        r_lo   <= w_lo_fix;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk, rst, start, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch an op and wait (bounded) for done. Cycle 1 is the one after the launch edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, output int dcyc, output int bcnt,
                        output logic busy_at_done);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    dcyc = 0; bcnt = 0; busy_at_done = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (inject && c == 5) begin
        start = 1'b1; op = 3'b011; a = $urandom; b = $urandom_range(1, 9);
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dcyc = c; busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0)   begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0)   begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int d, bc; logic bd;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, d, bc, bd);
    n_checks++; if (d !== 34)             begin n_fail++; $display("FAIL multu_done_cycle: got %0d want 34", d); end
    n_checks++; if (bc !== 33)            begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
    n_checks++; if (bd !== 1'b0)          begin n_fail++; $display("FAIL multu_busy_at_done: got %b want 0", bd); end
    n_checks++; if (hi !== 32'hFFFFFFFE)  begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_checks++; if (lo !== 32'h00000001)  begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_signed();
    int d, bc; logic bd;
    run_op(3'b000, 32'hFFFFFFFD, 32'd7, 1'b0, d, bc, bd);
    n_checks++; if (hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFFFFEB)  begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, d, bc, bd);
    n_checks++; if (d !== 34)             begin n_fail++; $display("FAIL div_done_cycle: got %0d want 34", d); end
    n_checks++; if (lo !== 32'hFFFFFFFD)  begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
  endtask

  task automatic test_div_corner();
    int d, bc; logic bd;
    run_op(3'b011, 32'h12345678, 32'h0, 1'b0, d, bc, bd);
    n_checks++; if (d !== 34)             begin n_fail++; $display("FAIL divu0_done_cycle: got %0d want 34", d); end
    n_checks++; if (lo !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'h12345678)  begin n_fail++; $display("FAIL divu0_hi: got %h want 12345678", hi); end
    run_op(3'b010, 32'hFFFFFFF9, 32'h0, 1'b0, d, bc, bd);
    n_checks++; if (lo !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'hFFFFFFF9)  begin n_fail++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, d, bc, bd);
    n_checks++; if (lo !== 32'h80000000)  begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h00000000)  begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int d, bc; logic bd;
    run_op(3'b100, 32'hDEADBEEF, 32'h0, 1'b0, d, bc, bd);
    n_checks++; if (d !== 1)              begin n_fail++; $display("FAIL mthi_done_cycle: got %0d want 1", d); end
    n_checks++; if (bd !== 1'b0)          begin n_fail++; $display("FAIL mthi_busy: got %b want 0", bd); end
    n_checks++; if (hi !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL mthi_hi: got %h want deadbeef", hi); end
    n_checks++; if (lo !== 32'h80000000)  begin n_fail++; $display("FAIL mthi_lo_held: got %h want 80000000", lo); end
    run_op(3'b101, 32'hCAFEF00D, 32'h0, 1'b0, d, bc, bd);
    n_checks++; if (d !== 1)              begin n_fail++; $display("FAIL mtlo_done_cycle: got %0d want 1", d); end
    n_checks++; if (bc !== 0)             begin n_fail++; $display("FAIL mtlo_busy_cycles: got %0d want 0", bc); end
    n_checks++; if (lo !== 32'hCAFEF00D)  begin n_fail++; $display("FAIL mtlo_lo: got %h want cafef00d", lo); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (hi !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL mt_hold_hi: got %h want deadbeef", hi); end
    n_checks++; if (lo !== 32'hCAFEF00D)  begin n_fail++; $display("FAIL mt_hold_lo: got %h want cafef00d", lo); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL mt_hold_done: got %b want 0", done); end
  endtask

  task automatic test_ignored_op();
    int d, bc; logic bd;
    run_op(3'b110, 32'h11111111, 32'h22222222, 1'b0, d, bc, bd);
    n_checks++; if (d !== 0)              begin n_fail++; $display("FAIL op110_done: got cycle %0d want none", d); end
    n_checks++; if (bc !== 0)             begin n_fail++; $display("FAIL op110_busy: got %0d want 0", bc); end
    n_checks++; if (lo !== 32'hCAFEF00D)  begin n_fail++; $display("FAIL op110_lo: got %h want cafef00d", lo); end
  endtask

  task automatic test_start_while_busy();
    int d, bc; logic bd;
    run_op(3'b001, 32'h00010003, 32'h00020005, 1'b1, d, bc, bd);
    n_checks++; if (d !== 34)             begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d want 34", d); end
    n_checks++; if (hi !== 32'h00000002)  begin n_fail++; $display("FAIL busy_start_hi: got %h want 00000002", hi); end
    n_checks++; if (lo !== 32'h000B000F)  begin n_fail++; $display("FAIL busy_start_lo: got %h want 000b000f", lo); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL busy_start_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int d, bc; logic bd;
    run_op(3'b001, 32'd100, 32'd100, 1'b0, d, bc, bd);
    n_checks++; if (lo !== 32'd10000)     begin n_fail++; $display("FAIL b2b_mul_lo: got %h want 00002710", lo); end
    run_op(3'b011, 32'd10000, 32'd7, 1'b0, d, bc, bd);
    n_checks++; if (d !== 34)             begin n_fail++; $display("FAIL b2b_div_done_cycle: got %0d want 34", d); end
    n_checks++; if (lo !== 32'd1428)      begin n_fail++; $display("FAIL b2b_div_lo: got %h want 00000594", lo); end
    n_checks++; if (hi !== 32'd4)         begin n_fail++; $display("FAIL b2b_div_hi: got %h want 00000004", hi); end
  endtask

  task automatic test_reset_mid_op();
    int d, bc; logic bd; logic seen;
    start = 1'b1; op = 3'b010; a = 32'hFFFFFF9C; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL midrst_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0)         begin n_fail++; $display("FAIL midrst_lo: got %h want 0", lo); end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0)        begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", seen); end
    run_op(3'b001, 32'd6, 32'd7, 1'b0, d, bc, bd);
    n_checks++; if (lo !== 32'd42)        begin n_fail++; $display("FAIL midrst_mul_lo: got %h want 0000002a", lo); end
    n_checks++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL midrst_mul_hi: got %h want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corner();
    test_mthi_mtlo();
    test_ignored_op();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
